// File: rtl/conv_mac_seq.sv
// Sequential 5x5 convolution MAC: walks the kernel taps one per cycle, multiplies each
// unsigned pixel by a signed weight and accumulates. Optional ReLU via CONV_MAC_RELU_EN.
module conv_mac_seq #(
   parameter int W     = 8,
   parameter int TAPS  = 25,
   parameter int ACC_W = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     img_in,
   input  logic             w_we,
   input  logic [4:0]       w_addr,
   input  logic [W-1:0]     w_data,
   output logic [4:0]       select,
   output logic             busy,
   output logic [ACC_W-1:0] result,
   output logic             valid
);

   localparam int PW = 2 * W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);
   localparam logic [4:0] NO_TAP   = 5'(TAPS);

   logic [1:0]              state;
   logic [4:0]              k;
   logic                    pv;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    prod_next;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] res_next;
   logic signed [W-1:0]     w [TAPS];

   always_comb begin
      // Pixel is zero-extended so it stays non-negative in the signed multiply.
      prod_next = $signed({1'b0, img_in}) * w[k];
      prod_ext  = {{(ACC_W - PW){prod[PW-1]}}, prod};
      sum       = acc + prod_ext;
`ifdef CONV_MAC_RELU_EN
      res_next  = sum[ACC_W-1] ? '0 : sum;
`else
      res_next  = sum;
`endif
   end

   assign busy   = (state == RUN) || (state == DRAIN);
   assign select = (state == RUN) ? k : NO_TAP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         acc    <= '0;
         prod   <= '0;
         pv     <= 1'b0;
         result <= '0;
         valid  <= 1'b0;
         for (int i = 0; i < TAPS; i++) w[i] <= '0;
      end else begin
         valid <= 1'b0;
         if (pv) acc <= acc + prod_ext;
         case (state)
            IDLE: begin
               if (w_we && (w_addr < NO_TAP)) w[w_addr] <= w_data;
               if (start) begin
                  state <= RUN;
                  acc   <= '0;
                  k     <= '0;
                  pv    <= 1'b0;
               end
            end
            RUN: begin
               prod <= prod_next;
               pv   <= 1'b1;
               k    <= k + 5'd1;
               if (k == LAST_TAP) state <= DRAIN;
            end
            DRAIN: begin
               // Last product is still in flight, so fold it in directly.
               result <= res_next;
               valid  <= 1'b1;
               pv     <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomized self-checking bench for conv_mac_seq against a sum-of-products reference.
// Build with +define+CONV_MAC_RELU_EN to check the ReLU variant.
module tb_conv_mac_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  img_in;
   logic        w_we;
   logic [4:0]  w_addr;
   logic [7:0]  w_data;
   logic [4:0]  select;
   logic        busy;
   logic [20:0] result;
   logic        valid;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]        img_arr [25];
   logic signed [7:0] ref_w   [25];

   always #5 clk = ~clk;

   // Upstream window PE: combinational pixel for the current select, 0 for index 25.
   always_comb begin
      img_in = 8'd0;
      if (select < 5'd25) img_in = img_arr[select];
   end

   conv_mac_seq #(.W(8), .TAPS(25), .ACC_W(21)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .img_in (img_in),
      .w_we   (w_we),
      .w_addr (w_addr),
      .w_data (w_data),
      .select (select),
      .busy   (busy),
      .result (result),
      .valid  (valid)
   );

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int relu_fn(input int s);
`ifdef CONV_MAC_RELU_EN
      return (s < 0) ? 0 : s;
`else
      return s;
`endif
   endfunction

   function automatic int ref_result();
      int s = 0;
      for (int i = 0; i < 25; i++) s += int'(img_arr[i]) * int'(ref_w[i]);
      return relu_fn(s);
   endfunction

   function automatic int res_int();
      return int'($signed(result));
   endfunction

   task automatic write_w(input int addr, input int data);
      w_we   = 1'b1;
      w_addr = 5'(addr);
      w_data = 8'(data);
      @(negedge clk);
      w_we = 1'b0;
      if (addr < 25) ref_w[addr] = 8'(data);
   endtask

   task automatic load_all(input int data);
      for (int i = 0; i < 25; i++) write_w(i, data);
   endtask

   task automatic fill_img(input int v);
      for (int i = 0; i < 25; i++) img_arr[i] = 8'(v);
   endtask

   // Called at a negedge; returns at the negedge where valid should be high.
   task automatic run_conv(input string tag, input bit hold, input bit busy_wr);
      int exp_res = ref_result();
      start = 1'b1;
      for (int n = 0; n <= 25; n++) begin
         @(negedge clk);
         if (n == 0) begin
            w_we = 1'b0;
            if (!hold) start = 1'b0;
         end
         if (busy_wr && n == 5) begin
            w_we = 1'b1; w_addr = 5'd0; w_data = 8'd5;
         end
         if (busy_wr && n == 6) w_we = 1'b0;
         check({tag, ".sel"}, int'(select), (n <= 24) ? n : 25);
         if (n == 0 || n == 25) begin
            check({tag, ".busy"}, int'(busy), 1);
            check({tag, ".novalid"}, int'(valid), 0);
         end
      end
      @(negedge clk);
      check({tag, ".valid"}, int'(valid), 1);
      check({tag, ".busy_lo"}, int'(busy), 0);
      check({tag, ".result"}, res_int(), exp_res);
   endtask

   initial begin
      int vcount;
      rst = 1'b1; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
      fill_img(0);
      for (int i = 0; i < 25; i++) ref_w[i] = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst.busy", int'(busy), 0);
      check("rst.valid", int'(valid), 0);
      check("rst.result", res_int(), 0);
      check("rst.select", int'(select), 25);
      rst = 1'b0;
      @(negedge clk);

      // Weights come out of reset as zero.
      fill_img(10);
      run_conv("zero_w", 1'b0, 1'b0);

      load_all(1);
      run_conv("ones", 1'b0, 1'b0);

      fill_img(255);
      load_all(127);
      run_conv("max_pos", 1'b0, 1'b0);
      load_all(-128);
      run_conv("max_neg", 1'b0, 1'b0);

      load_all(0);
      write_w(12, 2);
      fill_img(7);
      img_arr[12] = 8'd100;
      run_conv("center", 1'b0, 1'b0);

      // Write and start on the same edge: run sees the new weight.
      load_all(1);
      fill_img(10);
      w_we = 1'b1; w_addr = 5'd3; w_data = 8'hFD;
      ref_w[3] = -8'sd3;
      run_conv("wr_start", 1'b0, 1'b0);

      // Out-of-range address must not alias onto a real tap.
      write_w(27, 99);
      write_w(25, -50);
      run_conv("oob_wr", 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 25; i++) begin
            img_arr[i] = 8'($urandom_range(0, 255));
            write_w(i, $urandom_range(0, 255));
         end
         run_conv("rand", 1'b0, 1'b0);
      end

      // Reset mid-run: abort with no valid pulse, weights cleared.
      load_all(1);
      fill_img(10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vcount = 0;
      while (select != 5'd10 && vcount < 40) begin
         @(negedge clk);
         vcount++;
      end
      check("mid_rst.reach", int'(select), 10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 25; i++) ref_w[i] = '0;
      check("mid_rst.busy", int'(busy), 0);
      check("mid_rst.result", res_int(), 0);
      check("mid_rst.select", int'(select), 25);
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         if (valid) vcount++;
         @(negedge clk);
      end
      check("mid_rst.nopulse", vcount, 0);
      run_conv("post_rst_zero", 1'b0, 1'b0);
      load_all(1);
      run_conv("post_rst", 1'b0, 1'b0);

      // Start held high: back-to-back runs every 27 cycles; busy write ignored.
      fill_img(1);
      run_conv("b2b0", 1'b1, 1'b0);
      run_conv("b2b1", 1'b1, 1'b1);
      run_conv("b2b2", 1'b1, 1'b0);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("idle.valid", int'(valid), 0);
      check("idle.busy", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
